hub75_scan_ctrl: RTL
====================

Name: hub75_scan_ctrl

Overview:
Parametrised HUB75 scan controller: sequences rows and binary-coded-modulation bit planes, drives latch/blank/row-select pins, and triggers the fetch/shift engine one plane ahead of display. Adds over the current main FSM: selectable row-select mode (shift-register or parallel address), runtime global brightness, frame-start strobe. Sits between the fetch/shift engine and the panel pins.

Parameters:
ROWS, 32, scan rows per frame (2..2^ADDR_W)
BITS, 6, bit planes per row (1..12)
ADDR_W, 5, row index / parallel address width
SHOW_LEN, 32, on-time in sys_clk cycles of bit plane 0 at full brightness
DLY_W, 20, on-time counter width; must hold SHOW_LEN<<(BITS-1)
ADDR_MODE, 0, 0 = shift-register row select (row_clk/row_data); 1 = parallel addr bus

Ports:
sys_clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
fetchshift_busy  in  1  fetch/shift engine busy
brightness  in  8  global brightness, sampled at each SHOW_START
fetchshift_start  out  1  one-cycle pulse: load plane (row_out, bit_out)
row_out  out  ADDR_W  row of plane being fetched
bit_out  out  4  bit plane being fetched
frame_start  out  1  one-cycle pulse when row 0 / bit 0 is latched
lat  out  1  pin: latch
blank  out  1  pin: output enable, high = dark
row_clk  out  1  pin: row shift clock (ADDR_MODE=0)
row_data  out  1  pin: row shift data (ADDR_MODE=0)
addr  out  ADDR_W  pin: parallel row address (ADDR_MODE=1)

Behaviour:
- Reset (async): state IDLE; lat=0, blank=1, row_clk=0, row_data=0, addr=0, fetchshift_start=0, frame_start=0; display and fetch counters = (row 0, bit 0).
- Order: per row, bits 0..BITS-1; rows 0..ROWS-1; wrap to row 0 / bit 0. Fetch coordinate always = successor of displayed plane.
- States: IDLE -> PRELOAD (start pulse, fetch 0/0) -> PRELOAD_WAIT (until !busy) -> ROW_SEL -> ADDR_DATA -> ADDR_CLK -> ADDR_HOLD -> LATCH -> LATCH_HOLD -> SHOW_START -> SHOW_WAIT -> ADVANCE -> ROW_SEL.
- ROW_SEL: if displayed bit != 0, skip straight to LATCH. ADDR_MODE=0: ADDR_DATA drives row_data = (row==0); ADDR_CLK raises row_clk with data held; ADDR_HOLD drops clk, data held. ADDR_MODE=1: addr updates in ADDR_DATA; ADDR_CLK/ADDR_HOLD are settle cycles; row_clk/row_data stay 0.
- LATCH/LATCH_HOLD: lat=1 both cycles; blank=1 throughout address and latch phases.
- SHOW_START: fetchshift_start pulse for successor plane; on-time counter cleared; on_len = ((SHOW_LEN << bit) * (brightness+1)) >> 8, truncated.
- SHOW_WAIT: counter increments; blank=0 while counter < on_len; exit when counter >= on_len and !fetchshift_busy (plane period = max of both).
- on_len = 0 (small SHOW_LEN, low brightness): plane stays blank, sequencing unchanged.
- ADVANCE: displayed coordinate <= successor.
- frame_start: pulse in LATCH when displayed plane is (0,0).
- All pin outputs (lat, blank, row_clk, row_data, addr) registered: one cycle after state decode. fetchshift_start, frame_start, row_out, bit_out combinational from state/counters.
- busy asserted at IDLE/reset: ignored until PRELOAD_WAIT.

Optional Feature:
HUB75_FRAME_SWAP_EN: adds input swap_req (level) and output frame_swap (1 pulse). If swap_req is high in LATCH_HOLD of last plane (ROWS-1, BITS-1), frame_swap pulses that cycle, one cycle before the SHOW_START that fetches (0,0). Lets the framebuffer switch banks tear-free. Undefined: ports absent, no swap logic.

Test Plan:
ROWS=4, BITS=2, ADDR_MODE=0, busy model 10 cycles -> fetch order (0,0),(0,1),(1,0)...(3,1),(0,0); row_data=1 only on row 0 clock; one row_clk per row.
SHOW_LEN=32, brightness=255, busy 10 -> blank low 32 cycles bit 0, 64 cycles bit 1.
brightness=127 -> on-times 16/32; brightness=0 -> on-time 0, blank never low, order intact.
busy held 200 cycles, on_len 32 -> SHOW_WAIT lasts 200 cycles, blank high after 32.
ADDR_MODE=1, ROWS=4 -> addr steps 0,1,2,3,0 while blank=1 and lat=0; row_clk, row_data always 0.
rst asserted mid SHOW_WAIT -> same cycle outputs return to reset values; after release, PRELOAD fetches (0,0); with HUB75_FRAME_SWAP_EN and swap_req=1, exactly one frame_swap per frame.

Source files
------------

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan controller: walks rows and BCM bit planes, drives lat/blank/row-select
// pins and kicks the fetch/shift engine one plane ahead. Optional: HUB75_FRAME_SWAP_EN.
module hub75_scan_ctrl #(
  parameter int ROWS      = 32,
  parameter int BITS      = 6,
  parameter int ADDR_W    = 5,
  parameter int SHOW_LEN  = 32,
  parameter int DLY_W     = 20,
  parameter int ADDR_MODE = 0
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              fetchshift_busy,
  input  logic [7:0]        brightness,
  output logic              fetchshift_start,
  output logic [ADDR_W-1:0] row_out,
  output logic [3:0]        bit_out,
  output logic              frame_start,
  output logic              lat,
  output logic              blank,
  output logic              row_clk,
  output logic              row_data,
  output logic [ADDR_W-1:0] addr
`ifdef HUB75_FRAME_SWAP_EN
  ,
  input  logic              swap_req,
  output logic              frame_swap
`endif
);

  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS - 1);
  localparam logic [3:0]        BIT_LAST = 4'(BITS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PRELOAD, S_PRELOAD_WAIT, S_ROW_SEL, S_ADDR_DATA, S_ADDR_CLK,
    S_ADDR_HOLD, S_LATCH, S_LATCH_HOLD, S_SHOW_START, S_SHOW_WAIT, S_ADVANCE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   row_q, row_d;
  logic [3:0]          bit_q, bit_d;
  logic [DLY_W-1:0]    cnt_q, cnt_d;
  logic [DLY_W-1:0]    on_len_q, on_len_d;
  logic                lat_q, lat_d;
  logic                blank_q, blank_d;
  logic                row_clk_q, row_clk_d;
  logic                row_data_q, row_data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  logic [ADDR_W-1:0]   succ_row;
  logic [3:0]          succ_bit;
  logic [DLY_W-1:0]    base_len;
  logic [DLY_W+8:0]    scaled_len;
  logic                addr_phase;

  // Successor of the displayed plane: bits first, then rows, wrapping to (0,0).
  always_comb begin
    succ_row = row_q;
    succ_bit = bit_q + 4'd1;
    if (bit_q == BIT_LAST) begin
      succ_bit = 4'd0;
      succ_row = (row_q == ROW_LAST) ? '0 : row_q + ADDR_W'(1);
    end
  end

  // On-time scales with plane weight and brightness; (b+1)/256 so 255 is full scale.
  always_comb begin
    base_len   = DLY_W'(SHOW_LEN) << bit_q;
    scaled_len = {9'd0, base_len} * (DLY_W+9)'({1'b0, brightness} + 9'd1);
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    on_len_d = on_len_q;
    case (state_q)
      S_IDLE:         state_d = S_PRELOAD;
      S_PRELOAD:      state_d = S_PRELOAD_WAIT;
      S_PRELOAD_WAIT: if (!fetchshift_busy) state_d = S_ROW_SEL;
      S_ROW_SEL:      state_d = (bit_q != 4'd0) ? S_LATCH : S_ADDR_DATA;
      S_ADDR_DATA:    state_d = S_ADDR_CLK;
      S_ADDR_CLK:     state_d = S_ADDR_HOLD;
      S_ADDR_HOLD:    state_d = S_LATCH;
      S_LATCH:        state_d = S_LATCH_HOLD;
      S_LATCH_HOLD:   state_d = S_SHOW_START;
      S_SHOW_START: begin
        cnt_d    = '0;
        on_len_d = scaled_len[DLY_W+7:8];
        state_d  = S_SHOW_WAIT;
      end
      S_SHOW_WAIT: begin
        // Counter saturates at on_len so a long busy cannot wrap it.
        if (cnt_q >= on_len_q) begin
          if (!fetchshift_busy) state_d = S_ADVANCE;
        end else begin
          cnt_d = cnt_q + DLY_W'(1);
        end
      end
      S_ADVANCE: begin
        row_d   = succ_row;
        bit_d   = succ_bit;
        state_d = S_ROW_SEL;
      end
      default:        state_d = S_IDLE;
    endcase
  end

  assign addr_phase = (state_q == S_ADDR_DATA) || (state_q == S_ADDR_CLK) ||
                      (state_q == S_ADDR_HOLD);

  always_comb begin
    lat_d      = (state_q == S_LATCH) || (state_q == S_LATCH_HOLD);
    blank_d    = !((state_q == S_SHOW_WAIT) && (cnt_q < on_len_q));
    row_clk_d  = 1'b0;
    row_data_d = 1'b0;
    addr_d     = addr_q;
    if (ADDR_MODE == 0) begin
      row_clk_d  = (state_q == S_ADDR_CLK);
      row_data_d = addr_phase && (row_q == '0);
      addr_d     = '0;
    end else if (state_q == S_ADDR_DATA) begin
      addr_d = row_q;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      bit_q      <= '0;
      cnt_q      <= '0;
      on_len_q   <= '0;
      lat_q      <= 1'b0;
      blank_q    <= 1'b1;
      row_clk_q  <= 1'b0;
      row_data_q <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      bit_q      <= bit_d;
      cnt_q      <= cnt_d;
      on_len_q   <= on_len_d;
      lat_q      <= lat_d;
      blank_q    <= blank_d;
      row_clk_q  <= row_clk_d;
      row_data_q <= row_data_d;
      addr_q     <= addr_d;
    end
  end

  // The preload fetches the displayed plane itself; every later fetch is one ahead.
  assign fetchshift_start = (state_q == S_PRELOAD) || (state_q == S_SHOW_START);
  assign row_out          = (state_q == S_PRELOAD) ? row_q : succ_row;
  assign bit_out          = (state_q == S_PRELOAD) ? bit_q : succ_bit;
  assign frame_start      = (state_q == S_LATCH) && (row_q == '0) && (bit_q == 4'd0);

  assign lat      = lat_q;
  assign blank    = blank_q;
  assign row_clk  = row_clk_q;
  assign row_data = row_data_q;
  assign addr     = addr_q;

`ifdef HUB75_FRAME_SWAP_EN
  assign frame_swap = swap_req && (state_q == S_LATCH_HOLD) &&
                      (row_q == ROW_LAST) && (bit_q == BIT_LAST);
`endif

endmodule
